// File: rtl/vga_line_fetch.sv
// Line prefetcher: reads one display line from SDRAM in bursts into a show-ahead pixel FIFO.
// Optional VGA_LINE_FETCH_STATS_EN adds a saturating underflow counter output.
module vga_line_fetch #(
    parameter int WordLength   = 16,
    parameter int AddressWidth = 24,
    parameter int BurstLength  = 8,
    parameter int LineWords    = 640,
    parameter int FifoDepth    = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_frame_start,
    input  logic [AddressWidth-1:0] i_base_addr,
    input  logic                    i_line_start,
    input  logic                    i_pop,
    output logic [WordLength-1:0]   o_pixel,
    output logic                    o_pixel_valid,
    output logic                    o_underflow,
`ifdef VGA_LINE_FETCH_STATS_EN
    output logic [15:0]             o_underflow_count,
`endif
    output logic                    o_line_done,
    output logic                    o_mem_en,
    output logic                    o_mem_rw,
    output logic [AddressWidth-1:0] o_mem_addr,
    input  logic                    i_mem_busy,
    input  logic                    i_mem_valid,
    input  logic [WordLength-1:0]   i_mem_data
);

    localparam int PW = $clog2(FifoDepth);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BurstLength + 1);
    localparam int WW = $clog2(LineWords + 1);

    localparam logic [BW-1:0] BEAT_LAST        = BW'(BurstLength - 1);
    localparam logic [WW-1:0] LAST_BURST_START = WW'(LineWords - BurstLength);
    localparam logic [WW-1:0] BURST_WORDS      = WW'(BurstLength);
    localparam logic [CW-1:0] FIFO_FULL        = CW'(FifoDepth);
    localparam logic [CW-1:0] BURST_ROOM       = CW'(BurstLength);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        ISSUE,
        RECEIVE,
        DRAIN,
        LINE_DONE
    } state_t;

    state_t                  state_q;
    logic [AddressWidth-1:0] ptr_q;
    logic [WW-1:0]           words_q;
    logic [BW-1:0]           beat_q;
    logic                    mem_en_q;
    logic [AddressWidth-1:0] mem_addr_q;
    logic                    line_done_q;

    logic [WordLength-1:0]   mem_q [FifoDepth];
    logic [PW-1:0]           wr_q, wr_d;
    logic [PW-1:0]           rd_q, rd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    underflow_q, underflow_d;

    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    underflow_evt;
    logic [CW-1:0]           free_entries;

    assign fifo_empty    = (cnt_q == '0);
    assign fifo_full     = (cnt_q == FIFO_FULL);
    assign free_entries  = FIFO_FULL - cnt_q;
    assign push          = (state_q == RECEIVE) && i_mem_valid && !i_frame_start && !fifo_full;
    assign pop           = i_pop && !fifo_empty && !i_frame_start;
    assign underflow_evt = i_pop && fifo_empty;

    always_comb begin
        wr_d        = wr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        underflow_d = underflow_q | underflow_evt;
        if (i_frame_start) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // FIFO storage holds data only, so it carries no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_q] <= i_mem_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            words_q     <= '0;
            beat_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            if (i_frame_start) begin
                ptr_q    <= i_base_addr;
                words_q  <= '0;
                mem_en_q <= 1'b0;
                // A burst already owned by the controller must be drained before going idle
                if (state_q == RECEIVE || state_q == DRAIN) begin
                    if (i_mem_valid && beat_q == BEAT_LAST) begin
                        state_q <= IDLE;
                        beat_q  <= '0;
                    end else begin
                        state_q <= DRAIN;
                        beat_q  <= beat_q + BW'(i_mem_valid);
                    end
                end else if (state_q == ISSUE && !i_mem_busy) begin
                    state_q <= DRAIN;
                    beat_q  <= '0;
                end else begin
                    state_q <= IDLE;
                    beat_q  <= '0;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_line_start) begin
                            state_q <= WAIT_SPACE;
                            words_q <= '0;
                        end
                    end
                    WAIT_SPACE: begin
                        if (free_entries >= BURST_ROOM) begin
                            state_q    <= ISSUE;
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= ptr_q;
                        end
                    end
                    ISSUE: begin
                        if (!i_mem_busy) begin
                            state_q  <= RECEIVE;
                            mem_en_q <= 1'b0;
                            beat_q   <= '0;
                        end
                    end
                    RECEIVE: begin
                        if (i_mem_valid) begin
                            if (beat_q == BEAT_LAST) begin
                                beat_q  <= '0;
                                ptr_q   <= ptr_q + AddressWidth'(BurstLength);
                                words_q <= words_q + BURST_WORDS;
                                if (words_q == LAST_BURST_START) begin
                                    state_q     <= LINE_DONE;
                                    line_done_q <= 1'b1;
                                end else begin
                                    state_q <= WAIT_SPACE;
                                end
                            end else begin
                                beat_q <= beat_q + BW'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        if (i_mem_valid) begin
                            if (beat_q == BEAT_LAST) begin
                                state_q <= IDLE;
                                beat_q  <= '0;
                            end else begin
                                beat_q <= beat_q + BW'(1);
                            end
                        end
                    end
                    LINE_DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef VGA_LINE_FETCH_STATS_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ucnt_q <= '0;
        end else if (i_frame_start) begin
            ucnt_q <= '0;
        end else if (underflow_evt && ucnt_q != 16'hFFFF) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign o_underflow_count = ucnt_q;
`endif

    assign o_pixel       = fifo_empty ? '0 : mem_q[rd_q];
    assign o_pixel_valid = !fifo_empty;
    assign o_underflow   = underflow_q;
    assign o_line_done   = line_done_q;
    assign o_mem_en      = mem_en_q;
    assign o_mem_rw      = 1'b1;
    assign o_mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch: table of whole-line scenarios against an SDRAM controller model,
// plus hand sequences for reset, underflow, FIFO back-pressure and frame restart mid-burst.
module tb_vga_line_fetch;

    localparam int WL = 16;
    localparam int AW = 24;
    localparam int BL = 8;
    localparam int LW = 640;
    localparam int FD = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          i_frame_start;
    logic [AW-1:0] i_base_addr;
    logic          i_line_start;
    logic          i_pop;
    logic [WL-1:0] o_pixel;
    logic          o_pixel_valid;
    logic          o_underflow;
`ifdef VGA_LINE_FETCH_STATS_EN
    logic [15:0]   o_underflow_count;
`endif
    logic          o_line_done;
    logic          o_mem_en;
    logic          o_mem_rw;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_busy;
    logic          i_mem_valid;
    logic [WL-1:0] i_mem_data;

    vga_line_fetch #(
        .WordLength(WL), .AddressWidth(AW), .BurstLength(BL), .LineWords(LW), .FifoDepth(FD)
    ) dut (
        .CLK(CLK), .RST(RST),
        .i_frame_start(i_frame_start), .i_base_addr(i_base_addr),
        .i_line_start(i_line_start), .i_pop(i_pop),
        .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid), .o_underflow(o_underflow),
`ifdef VGA_LINE_FETCH_STATS_EN
        .o_underflow_count(o_underflow_count),
`endif
        .o_line_done(o_line_done), .o_mem_en(o_mem_en), .o_mem_rw(o_mem_rw),
        .o_mem_addr(o_mem_addr), .i_mem_busy(i_mem_busy), .i_mem_valid(i_mem_valid),
        .i_mem_data(i_mem_data)
    );

    always #5 CLK = ~CLK;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SDRAM controller model: busy for busy_len cycles per request, then BL beats of a running counter
    int            busy_len = 2;
    bit            gaps = 1'b0;
    int            wait_ctr = 2;
    int            beats_left = 0;
    int            ctl_beats = 0;
    logic [WL-1:0] ctl_data = '0;
    logic [AW-1:0] req_q[$];

    initial begin
        i_mem_busy  = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_data  = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST !== 1'b1) begin
                beats_left  = 0;
                i_mem_valid = 1'b0;
                i_mem_busy  = 1'b0;
                wait_ctr    = busy_len;
            end else begin
                if (beats_left > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
                    i_mem_valid = 1'b1;
                    i_mem_data  = ctl_data;
                    ctl_data    = ctl_data + 1'b1;
                    ctl_beats++;
                    beats_left--;
                end else begin
                    i_mem_valid = 1'b0;
                    i_mem_data  = WL'($urandom);
                end
                if (o_mem_en) begin
                    if (wait_ctr > 0) begin
                        i_mem_busy = 1'b1;
                        wait_ctr--;
                    end else begin
                        i_mem_busy = 1'b0;
                        req_q.push_back(o_mem_addr);
                        beats_left = BL;
                        wait_ctr   = busy_len;
                    end
                end else begin
                    i_mem_busy = 1'b0;
                    wait_ctr   = busy_len;
                end
            end
        end
    end

    int            ld_cnt;
    int            en_cnt;
    int            pix_err;
    int            popped;
    logic [WL-1:0] exp_pix;

    // One clock: sample at the falling edge, then drive inputs for the next rising edge.
    // pop_mode 0 = never, 1 = whenever valid, 2 = random when valid
    task automatic cycle(input int pop_mode, input bit extra_ls);
        @(negedge CLK);
        if (o_line_done === 1'b1) ld_cnt++;
        if (o_mem_en === 1'b1) en_cnt++;
        i_line_start  = 1'b0;
        i_frame_start = 1'b0;
        i_pop         = 1'b0;
        if (o_pixel_valid === 1'b1 &&
            (pop_mode == 1 || (pop_mode == 2 && $urandom_range(0, 1) == 1))) begin
            if (o_pixel !== exp_pix) pix_err++;
            exp_pix = exp_pix + 1'b1;
            popped++;
            i_pop = 1'b1;
        end
        if (extra_ls && beats_left > 0 && $urandom_range(0, 7) == 0) i_line_start = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST           = 1'b0;
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        i_pop         = 1'b0;
        i_base_addr   = '0;
        repeat (3) @(negedge CLK);
        RST     = 1'b1;
        ld_cnt  = 0;
        en_cnt  = 0;
        pix_err = 0;
        popped  = 0;
        exp_pix = ctl_data;
    endtask

    task automatic frame(input logic [AW-1:0] base);
        cycle(0, 1'b0);
        i_frame_start = 1'b1;
        i_base_addr   = base;
        cycle(0, 1'b0);
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            lines;
        int            pop_mode;
        bit            extra_ls;
        int            busy;
        bit            gaps;
        int            exp_reqs;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_second;
        logic [AW-1:0] exp_last;
        int            exp_ld;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int r0, n, bad, b0, d0;

        tbl[0] = '{24'h000100, 1, 1, 1'b0, 2, 1'b0,  80, 24'h000100, 24'h000108, 24'h000378, 1};
        tbl[1] = '{24'h000100, 1, 2, 1'b1, 1, 1'b1,  80, 24'h000100, 24'h000108, 24'h000378, 1};
        tbl[2] = '{24'hFFFFF8, 1, 2, 1'b0, 3, 1'b0,  80, 24'hFFFFF8, 24'h000000, 24'h000270, 1};
        tbl[3] = '{24'h123400, 2, 2, 1'b1, 0, 1'b1, 160, 24'h123400, 24'h123408, 24'h1238F8, 2};

        RST = 1'b0;
        i_frame_start = 1'b0;
        i_line_start  = 1'b0;
        i_pop         = 1'b0;
        i_base_addr   = '0;

        // Reset state
        busy_len = 2;
        gaps     = 1'b0;
        do_reset();
        cycle(0, 1'b0);
        chk("rst_mem_en", o_mem_en, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_rw", o_mem_rw, 1);
        chk("rst_pixel", o_pixel, 0);
        chk("rst_pixel_valid", o_pixel_valid, 0);
        chk("rst_underflow", o_underflow, 0);
        chk("rst_line_done", o_line_done, 0);

        // Pop on an empty FIFO
        i_pop = 1'b1;
        cycle(0, 1'b0);
        chk("underflow_set", o_underflow, 1);
        chk("underflow_no_data", o_pixel_valid, 0);
        repeat (5) cycle(0, 1'b0);
        chk("underflow_sticky", o_underflow, 1);
`ifdef VGA_LINE_FETCH_STATS_EN
        chk("underflow_count", o_underflow_count, 1);
`endif

        // Whole-line scenarios
        for (int v = 0; v < 4; v++) begin
            busy_len = tbl[v].busy;
            gaps     = tbl[v].gaps;
            do_reset();
            r0 = req_q.size();
            frame(tbl[v].base);
            for (int l = 0; l < tbl[v].lines; l++) begin
                cycle(tbl[v].pop_mode, tbl[v].extra_ls);
                i_line_start = 1'b1;
                n = 0;
                while (ld_cnt < l + 1 && n < 20000) begin
                    cycle(tbl[v].pop_mode, tbl[v].extra_ls);
                    n++;
                end
                chk($sformatf("v%0d_line%0d_done_in_time", v, l), 32'(ld_cnt >= l + 1), 1);
            end
            n = 0;
            while ((o_pixel_valid === 1'b1 || n < 4) && n < 2000) begin
                cycle(1, 1'b0);
                n++;
            end
            repeat (20) cycle(0, 1'b0);
            chk($sformatf("v%0d_requests", v), req_q.size() - r0, tbl[v].exp_reqs);
            if (req_q.size() - r0 >= tbl[v].exp_reqs) begin
                chk($sformatf("v%0d_first_addr", v), req_q[r0], tbl[v].exp_first);
                chk($sformatf("v%0d_second_addr", v), req_q[r0 + 1], tbl[v].exp_second);
                chk($sformatf("v%0d_last_addr", v), req_q[r0 + tbl[v].exp_reqs - 1], tbl[v].exp_last);
            end
            bad = 0;
            for (int k = r0 + 1; k < req_q.size(); k++)
                if (req_q[k] !== AW'(req_q[k - 1] + BL)) bad++;
            chk($sformatf("v%0d_noncontiguous", v), bad, 0);
            chk($sformatf("v%0d_line_done_pulses", v), ld_cnt, tbl[v].exp_ld);
            chk($sformatf("v%0d_pixel_errors", v), pix_err, 0);
            chk($sformatf("v%0d_pixels_popped", v), popped, tbl[v].lines * LW);
            chk($sformatf("v%0d_no_underflow", v), o_underflow, 0);
        end

        // Consumer stalls: FIFO fills with four bursts, then one more needs eight free slots
        busy_len = 2;
        gaps     = 1'b0;
        do_reset();
        r0 = req_q.size();
        frame(24'h000000);
        cycle(0, 1'b0);
        i_line_start = 1'b1;
        repeat (400) cycle(0, 1'b0);
        chk("stall_requests", req_q.size() - r0, 4);
        chk("stall_valid", o_pixel_valid, 1);
        n = en_cnt;
        repeat (50) cycle(0, 1'b0);
        chk("stall_mem_en_quiet", en_cnt - n, 0);
        repeat (7) cycle(1, 1'b0);
        repeat (30) cycle(0, 1'b0);
        chk("stall_7_pops_no_req", req_q.size() - r0, 4);
        cycle(1, 1'b0);
        repeat (30) cycle(0, 1'b0);
        chk("stall_8_pops_req", req_q.size() - r0, 5);
        chk("stall_pixel_errors", pix_err, 0);
        if (req_q.size() - r0 >= 5) chk("stall_fifth_addr", req_q[r0 + 4], 24'h000020);

        // Frame restart after the third beat of a burst
        do_reset();
        r0 = req_q.size();
        b0 = ctl_beats;
        d0 = int'(ctl_data);
        frame(24'h000200);
        cycle(0, 1'b0);
        i_line_start = 1'b1;
        n = 0;
        while (ctl_beats - b0 < 3 && n < 500) begin
            cycle(0, 1'b0);
            n++;
        end
        chk("abort_third_beat_seen", 32'(ctl_beats - b0 >= 3), 1);
        cycle(0, 1'b0);
        chk("abort_fifo_had_data", o_pixel_valid, 1);
        i_frame_start = 1'b1;
        i_base_addr   = 24'h000400;
        cycle(0, 1'b0);
        chk("abort_fifo_flushed", o_pixel_valid, 0);
        n = 0;
        while (beats_left > 0 && n < 100) begin
            cycle(0, 1'b0);
            n++;
        end
        repeat (5) cycle(0, 1'b0);
        chk("abort_drained_empty", o_pixel_valid, 0);
        chk("abort_no_new_request", req_q.size() - r0, 1);
        chk("abort_no_line_done", ld_cnt, 0);
        i_line_start = 1'b1;
        n = 0;
        while (req_q.size() - r0 < 2 && n < 100) begin
            cycle(0, 1'b0);
            n++;
        end
        chk("abort_restart_requested", req_q.size() - r0, 2);
        if (req_q.size() - r0 >= 2) chk("abort_restart_addr", req_q[r0 + 1], 24'h000400);
        n = 0;
        while (o_pixel_valid !== 1'b1 && n < 100) begin
            cycle(0, 1'b0);
            n++;
        end
        chk("abort_first_new_pixel", o_pixel, WL'(d0 + BL));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
